// File: rtl/machine_x_pkg.sv
// Shared definitions for the machine_x serializer front end and the
// sequence-detector benches that sit behind it.
package machine_x_pkg;

    // Serializer control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Idle line level. All-ones matches the detector's reset history, so an
    // idle line can never complete a pattern on its own.
    localparam logic IDLE_BIT_DFLT = 1'b1;

    // Patterns recognised by the downstream machine_x detector.
    localparam logic [3:0] DET_PAT4 = 4'b0010;
    localparam logic [4:0] DET_PAT5 = 5'b01000;

endpackage

// File: rtl/machine_x_serializer.sv
// Parallel-to-serial front end for the machine_x detector. Words arrive over
// a load/ready handshake and leave one bit per clock on a registered output.
// A one-word holding register lets back-to-back words stream with no gap.
module machine_x_serializer
    import machine_x_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   LSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = IDLE_BIT_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             last,
    output logic [7:0]       word_cnt
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             out_q, out_d;
    logic             last_q, last_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic             accept;

    // Picks the bit at position c of word w in transmit order.
    function automatic logic tx_bit(input logic [WIDTH-1:0] w,
                                    input logic [CNT_W-1:0] c);
        logic [WIDTH-1:0] tmp;
        if (LSB_FIRST) begin
            tmp = w >> c;
            return tmp[0];
        end else begin
            tmp = w << c;
            return tmp[WIDTH-1];
        end
    endfunction

    assign ready  = reset & ~hold_valid_q;
    assign accept = load & ready;

    // Next-state logic: word sequencing, holding register and output bit.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sreg_d       = sreg_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        word_cnt_d   = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sreg_d    = data_in;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_LAST) begin
                    word_cnt_d = word_cnt_q + 8'd1;
                    bit_cnt_d  = '0;
                    if (hold_valid_q) begin
                        // ready is low here, so no new word can collide.
                        sreg_d       = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        sreg_d = data_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d       = data_in;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_d  = (state_d == ST_SHIFT) ? tx_bit(sreg_d, bit_cnt_d) : IDLE_BIT;
        last_d = (state_d == ST_SHIFT) && (bit_cnt_d == CNT_LAST);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            hold_valid_q <= 1'b0;
            out_q        <= IDLE_BIT;
            last_q       <= 1'b0;
            word_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_valid_q <= hold_valid_d;
            out_q        <= out_d;
            last_q       <= last_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    // Data registers; their contents are only meaningful under the control flags.
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
        hold_q <= hold_d;
    end

    assign out      = out_q;
    assign last     = last_q;
    assign busy     = (state_q == ST_SHIFT);
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_machine_x_serializer.sv
// Directed bench for machine_x_serializer (MSB-first and LSB-first builds),
// with a reference model of the machine_x detector on the serial line.
module tb_machine_x_serializer;
    import machine_x_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] data_in,  data_in2;
    logic       load,     load2;
    logic       ready,    ready2;
    logic       out,      out2;
    logic       busy,     busy2;
    logic       last,     last2;
    logic [7:0] word_cnt, word_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    machine_x_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready), .out(out), .busy(busy), .last(last), .word_cnt(word_cnt)
    );

    machine_x_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in2), .load(load2),
        .ready(ready2), .out(out2), .busy(busy2), .last(last2), .word_cnt(word_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the machine_x detector: all-ones history after reset,
    // registered z on completion of either pattern.
    logic [4:0] hist;
    logic       z;
    always @(posedge clk) begin
        if (!reset) begin
            hist <= 5'b11111;
            z    <= 1'b0;
        end else begin
            hist <= {hist[3:0], out};
            z    <= ({hist[2:0], out} == DET_PAT4) || ({hist[3:0], out} == DET_PAT5);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load  = 1'b0;
        load2 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    logic [7:0]  exp8;
    logic [7:0]  cap8;
    logic [15:0] cap16;
    logic [23:0] cap24;
    logic [11:0] zvec;
    logic [7:0]  words [3];
    int          acc_edge [3];
    int          k;
    logic        pre;
    int          zeros;

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        load2    = 1'b0;
        data_in  = 8'h00;
        data_in2 = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_out",   out,      1);
        check("rst_busy",  busy,     0);
        check("rst_last",  last,     0);
        check("rst_wcnt",  word_cnt, 0);
        check("rst_ready", ready,    0);
        reset = 1'b1;
        #1;
        check("rel_ready", ready,    1);

        // Single word A5, MSB first
        exp8    = 8'hA5;
        data_in = 8'hA5;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_bit%0d", i),  out,  exp8[7-i]);
            check($sformatf("a5_last%0d", i), last, (i == 7));
            check($sformatf("a5_busy%0d", i), busy, 1);
            tick();
        end
        check("a5_idle_out",  out,      1);
        check("a5_idle_busy", busy,     0);
        check("a5_wcnt",      word_cnt, 1);

        // Back-to-back A5 then 3C via holding register
        do_reset();
        data_in = 8'hA5;
        load    = 1'b1;
        tick();
        cap16[15] = out;
        data_in = 8'h3C;
        tick();
        cap16[14] = out;
        load = 1'b0;
        check("b2b_ready_held", ready, 0);
        for (int i = 13; i >= 0; i--) begin
            tick();
            cap16[i] = out;
        end
        check("b2b_bits", cap16, 16'hA53C);
        tick();
        check("b2b_idle_out", out,      1);
        check("b2b_busy",     busy,     0);
        check("b2b_wcnt",     word_cnt, 2);

        // Holding full: three words with load held high
        do_reset();
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        k        = 0;
        data_in  = words[0];
        load     = 1'b1;
        for (int c = 0; c < 24; c++) begin
            pre = ready & load;
            tick();
            cap24[23-c] = out;
            if (pre) begin
                acc_edge[k] = c;
                k++;
                if (k == 3) load = 1'b0;
                else data_in = words[k];
            end
        end
        check("full_cnt",  k, 3);
        check("full_acc0", acc_edge[0], 0);
        check("full_acc1", acc_edge[1], 1);
        check("full_acc2", acc_edge[2], 9);
        check("full_bits", cap24, 24'h112233);
        tick();
        check("full_idle", out,      1);
        check("full_wcnt", word_cnt, 3);

        // LSB-first build, word 01
        do_reset();
        data_in2 = 8'h01;
        load2    = 1'b1;
        tick();
        load2 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cap8[i] = out2;
            if (i == 0) check("lsb_last", last2, 1);
            tick();
        end
        check("lsb_bits", cap8,      8'b1000_0000);
        check("lsb_idle", out2,      1);
        check("lsb_wcnt", word_cnt2, 1);

        // Reset during bit 3 of 0F with 55 held
        do_reset();
        data_in = 8'h0F;
        load    = 1'b1;
        tick();
        data_in = 8'h55;
        tick();
        load = 1'b0;
        check("mid_held", ready, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mid_out",   out,   1);
        check("mid_busy",  busy,  0);
        check("mid_last",  last,  0);
        check("mid_ready", ready, 0);
        reset = 1'b1;
        #1;
        check("mid_rel_ready", ready,    1);
        check("mid_rel_wcnt",  word_cnt, 0);
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out !== 1'b1 || busy !== 1'b0) zeros++;
        end
        check("mid_no_ghost", zeros, 0);

        // Integration: F2 completes 0010 on the detector
        do_reset();
        data_in = 8'hF2;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 12; c++) begin
            zvec[c] = z;
            tick();
        end
        check("det_f2", zvec, 12'h100);

        // Integration: FF never matches
        do_reset();
        data_in = 8'hFF;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 12; c++) begin
            zvec[c] = z;
            tick();
        end
        check("det_ff", zvec, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
